fetch_redirect_unit: RTL and testbench

FETCH_REDIRECT_UNIT -- requirements
Module: fetch_redirect_unit

---
 rtl/fetch_redirect_unit.sv | 105 ++++++++++
 tb/tb_fetch_redirect_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fetch_redirect_unit.sv
// IF/ID pipeline register with branch/jump redirect resolved in ID and
// load-use stall handling; a taken redirect squashes the one wrong-path fetch.
module fetch_redirect_unit #(
   parameter logic [31:0] NOP_WORD    = 32'h00000000,
   parameter int unsigned STALL_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instructionIn,
   input  logic [31:0] pc4In,
   input  logic        loadUseHazard,
   input  logic [31:0] rsData,
   input  logic [31:0] rtData,
   output logic        pcFlush,
   output logic        outputBrachControl,
   output logic [31:0] pcBranch,
   output logic        jump,
   output logic [31:0] pcJump,
   output logic [31:0] instructionId,
   output logic [31:0] pc4Id,
   output logic        bubble,
   output logic        stallError
);

   typedef enum logic [1:0] {RUN, STALL, SQUASH} state_t;

   state_t            state;
   logic [2:0]        stallCount;
   logic [2:0]        stallCountNext;
   logic [5:0]        opcode;
   logic              isJump;
   logic              isBeq;
   logic              isBne;
   logic              taken;
   logic              redirectEn;
   logic              redirect;
   logic signed [31:0] branchOffset;

   function automatic logic [2:0] sat_inc(input logic [2:0] v);
      return (v == 3'd7) ? v : v + 3'd1;
   endfunction

   function automatic logic signed [31:0] branch_offset(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

   assign opcode       = instructionId[31:26];
   assign isJump       = (opcode == 6'h02) || (opcode == 6'h03);
   assign isBeq        = (opcode == 6'h04);
   assign isBne        = (opcode == 6'h05);
   assign taken        = isJump || (isBeq && (rsData == rtData)) || (isBne && (rsData != rtData));

   // A squash cycle holds a bubble in ID, so nothing there may steer the PC.
   assign redirectEn   = !loadUseHazard && (state != SQUASH);
   assign redirect     = redirectEn && taken;

   assign branchOffset       = branch_offset(instructionId[15:0]);
   assign pcBranch           = pc4Id + $unsigned(branchOffset);
   assign pcJump             = {pc4Id[31:28], instructionId[25:0], 2'b00};
   assign jump               = redirect && isJump;
   assign outputBrachControl = redirect && !isJump;
   assign pcFlush            = loadUseHazard;
   assign stallCountNext     = sat_inc(stallCount);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= RUN;
         stallCount    <= 3'd0;
         stallError    <= 1'b0;
         instructionId <= NOP_WORD;
         pc4Id         <= 32'h0;
         bubble        <= 1'b1;
      end else if (loadUseHazard) begin
         // IF/ID holds; the error flag latches once and survives the stall.
         state      <= STALL;
         stallCount <= stallCountNext;
         if (32'(stallCountNext) == STALL_LIMIT)
            stallError <= 1'b1;
      end else begin
         case (state)
            STALL: begin
               instructionId <= NOP_WORD;
               pc4Id         <= 32'h0;
               bubble        <= 1'b1;
               stallCount    <= 3'd0;
               state         <= RUN;
            end
            default: begin
               if (redirect) begin
                  instructionId <= NOP_WORD;
                  pc4Id         <= 32'h0;
                  bubble        <= 1'b1;
                  state         <= SQUASH;
               end else begin
                  instructionId <= instructionIn;
                  pc4Id         <= pc4In;
                  bubble        <= 1'b0;
                  state         <= RUN;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Bench for fetch_redirect_unit: vector table plus hazard and reset sequences,
// with post-edge IF/ID expectations queued at drive time and checked after the edge.
module tb_fetch_redirect_unit;

   localparam logic [31:0] ADDI = 32'h20080005;
   localparam logic [31:0] BEQ  = 32'h1000FFFF;
   localparam logic [31:0] JMP  = 32'h08000040;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instructionIn, pc4In, rsData, rtData;
   logic        loadUseHazard;
   logic        pcFlush, outputBrachControl, jump, bubble, stallError;
   logic [31:0] pcBranch, pcJump, instructionId, pc4Id;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        luh;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [2:0]  comb;   // {pcFlush, outputBrachControl, jump}
      logic        c_bt;
      logic [31:0] pcb;
      logic        c_jt;
      logic [31:0] pcj;
      logic [31:0] id;
      logic [31:0] pc4id;
      logic [1:0]  post;   // {bubble, stallError}
   } vec_t;

   typedef struct {
      logic [31:0] id;
      logic [31:0] pc4id;
      logic [1:0]  post;
      string       tag;
   } exp_t;

   vec_t vecs[12];
   exp_t sbq[$];

   fetch_redirect_unit #(.NOP_WORD(32'h00000000), .STALL_LIMIT(4)) dut (
      .clk(clk), .reset(reset),
      .instructionIn(instructionIn), .pc4In(pc4In),
      .loadUseHazard(loadUseHazard), .rsData(rsData), .rtData(rtData),
      .pcFlush(pcFlush), .outputBrachControl(outputBrachControl),
      .pcBranch(pcBranch), .jump(jump), .pcJump(pcJump),
      .instructionId(instructionId), .pc4Id(pc4Id),
      .bubble(bubble), .stallError(stallError)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " id"},     instructionId, 32'h0);
      chk({tag, " pc4id"},  pc4Id, 32'h0);
      chk({tag, " bubble"}, 32'(bubble), 32'h1);
      chk({tag, " err"},    32'(stallError), 32'h0);
      chk({tag, " redir"},  32'({outputBrachControl, jump}), 32'h0);
   endtask

   task automatic step(input vec_t v, input string tag);
      exp_t e;
      @(negedge clk);
      instructionIn = v.instr;
      pc4In         = v.pc4;
      loadUseHazard = v.luh;
      rsData        = v.rs;
      rtData        = v.rt;
      #1;
      chk({tag, " flush/br/jump"}, 32'({pcFlush, outputBrachControl, jump}), 32'(v.comb));
      if (v.c_bt) chk({tag, " pcBranch"}, pcBranch, v.pcb);
      if (v.c_jt) chk({tag, " pcJump"}, pcJump, v.pcj);
      e.id = v.id; e.pc4id = v.pc4id; e.post = v.post; e.tag = tag;
      sbq.push_back(e);
      @(posedge clk);
      #1;
      if (sbq.size() == 0) begin
         chk({tag, " scoreboard empty"}, 32'h1, 32'h0);
      end else begin
         e = sbq.pop_front();
         chk({e.tag, " id"},      instructionId, e.id);
         chk({e.tag, " pc4id"},   pc4Id, e.pc4id);
         chk({e.tag, " bub/err"}, 32'({bubble, stallError}), 32'(e.post));
      end
   endtask

   function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] pc4,
                               input logic luh, input logic [31:0] rs, input logic [31:0] rt,
                               input logic [2:0] comb,
                               input logic c_bt, input logic [31:0] pcb,
                               input logic c_jt, input logic [31:0] pcj,
                               input logic [31:0] id, input logic [31:0] pc4id,
                               input logic [1:0] post);
      vec_t v;
      v.instr = instr; v.pc4 = pc4; v.luh = luh; v.rs = rs; v.rt = rt;
      v.comb = comb; v.c_bt = c_bt; v.pcb = pcb; v.c_jt = c_jt; v.pcj = pcj;
      v.id = id; v.pc4id = pc4id; v.post = post;
      return v;
   endfunction

   initial begin
      vecs[0]  = mk(ADDI, 32'h4, 1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 32'h0, 1'b0, 32'h0, ADDI, 32'h4, 2'b00);
      vecs[1]  = mk(BEQ, 32'h10, 1'b0, 32'h0, 32'h0, 3'b000, 1'b1, 32'h18, 1'b1, 32'h00200014, BEQ, 32'h10, 2'b00);
      vecs[2]  = mk(32'h11111111, 32'h14, 1'b0, 32'h5, 32'h5, 3'b010, 1'b1, 32'hC, 1'b0, 32'h0, 32'h0, 32'h0, 2'b10);
      vecs[3]  = mk(32'h22222222, 32'h10, 1'b0, 32'h5, 32'h5, 3'b000, 1'b0, 32'h0, 1'b0, 32'h0, 32'h22222222, 32'h10, 2'b00);
      vecs[4]  = mk(BEQ, 32'h10, 1'b0, 32'h1, 32'h2, 3'b000, 1'b0, 32'h0, 1'b0, 32'h0, BEQ, 32'h10, 2'b00);
      vecs[5]  = mk(32'h33333333, 32'h14, 1'b0, 32'h1, 32'h2, 3'b000, 1'b1, 32'hC, 1'b0, 32'h0, 32'h33333333, 32'h14, 2'b00);
      vecs[6]  = mk(JMP, 32'hF0000008, 1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 32'h0, 1'b0, 32'h0, JMP, 32'hF0000008, 2'b00);
      vecs[7]  = mk(32'h44444444, 32'hF000000C, 1'b1, 32'h0, 32'h0, 3'b100, 1'b0, 32'h0, 1'b1, 32'hF0000100, JMP, 32'hF0000008, 2'b00);
      vecs[8]  = mk(32'h44444444, 32'hF000000C, 1'b0, 32'h0, 32'h0, 3'b001, 1'b0, 32'h0, 1'b1, 32'hF0000100, 32'h0, 32'h0, 2'b10);
      vecs[9]  = mk(JMP, 32'hF0000008, 1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 32'h0, 1'b0, 32'h0, JMP, 32'hF0000008, 2'b00);
      vecs[10] = mk(32'h55555555, 32'hF000000C, 1'b0, 32'h0, 32'h0, 3'b001, 1'b0, 32'h0, 1'b1, 32'hF0000100, 32'h0, 32'h0, 2'b10);
      vecs[11] = mk(ADDI, 32'hF0000104, 1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 32'h0, 1'b0, 32'h0, ADDI, 32'hF0000104, 2'b00);

      reset = 1'b0;
      instructionIn = ADDI; pc4In = 32'h4; loadUseHazard = 1'b0; rsData = 32'h0; rtData = 32'h0;
      #12;
      chk_reset("reset");
      chk("reset flush", 32'(pcFlush), 32'h0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 12; i++)
         step(vecs[i], $sformatf("vec%0d", i));

      // Five stall cycles: error appears on the 4th edge, then a load-use bubble.
      for (int k = 0; k < 5; k++)
         step(mk(32'h66666666, 32'h68, 1'b1, 32'h0, 32'h0, 3'b100, 1'b0, 32'h0, 1'b0, 32'h0,
                 ADDI, 32'hF0000104, (k >= 3) ? 2'b01 : 2'b00), $sformatf("stall%0d", k));
      step(mk(32'h66666666, 32'h68, 1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 32'h0, 1'b0, 32'h0,
              32'h0, 32'h0, 2'b11), "stall_release");
      step(mk(ADDI, 32'h4, 1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 32'h0, 1'b0, 32'h0,
              ADDI, 32'h4, 2'b01), "post_stall");

      // Reset pulsed in the middle of a stall.
      for (int k = 0; k < 2; k++)
         step(mk(32'h77777777, 32'h8, 1'b1, 32'h0, 32'h0, 3'b100, 1'b0, 32'h0, 1'b0, 32'h0,
                 ADDI, 32'h4, 2'b01), $sformatf("pre_rst%0d", k));
      @(negedge clk);
      reset = 1'b0;
      loadUseHazard = 1'b0;
      #1;
      chk_reset("mid_stall_reset");
      @(posedge clk);
      #1;
      chk_reset("held_reset");
      @(negedge clk);
      reset = 1'b1;
      step(mk(ADDI, 32'h4, 1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 32'h0, 1'b0, 32'h0,
              ADDI, 32'h4, 2'b00), "resume");
      step(mk(JMP, 32'h8, 1'b0, 32'h0, 32'h0, 3'b000, 1'b0, 32'h0, 1'b0, 32'h0,
              JMP, 32'h8, 2'b00), "resume2");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
